// File: rtl/fuzzy_defuzzy_seq.sv
// Serial type-2 (Nie-Tan) defuzzifier: accumulates per-rule weighted sums, then restoring-divides.
// Build option FUZZY_ROUND_EN: round-half-up quotient instead of truncation.
module fuzzy_defuzzy_seq #(
  parameter  int W       = 8,
  parameter  int N_RULES = 9,
  localparam int CW      = $clog2(N_RULES+1)
) (
  input  logic          clk_0,
  input  logic          Srst_n,
  input  logic          EN_REGRAS,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  input  logic [W-1:0]  in_up,
  input  logic [W-1:0]  in_low,
  input  logic [W-1:0]  in_cent,
  output logic          out_valid,
  output logic [W-1:0]  saida_defuzzy,
  output logic [CW-1:0] n_regras,
  output logic          out_zero,
  output logic          out_ovf,
  output logic          busy
);
  localparam int NW = 2*W+1+CW;
  localparam int DW = W+1+CW;
  localparam int SW = $clog2(W+1);

  typedef enum logic [1:0] {S_ACC, S_DIV, S_OUT} state_t;

  state_t        state_q;
  logic [NW-1:0] num_q, rem_q, dsh_q;
  logic [DW-1:0] den_q;
  logic [CW-1:0] cnt_q, ncnt_q;
  logic          ovf_p_q;
  logic [W-1:0]  quo_q;
  logic [SW-1:0] step_q;

  logic          out_valid_q, out_zero_q, out_ovf_q;
  logic [W-1:0]  saida_q;
  logic [CW-1:0] n_regras_q;

  logic [W:0]    s;
  logic [2*W:0]  prod;
  logic [NW-1:0] num_nx, div_ld;
  logic [DW-1:0] den_nx;
  logic [CW-1:0] cnt_nx;
  logic          cap, xfer, frame_end, ge;
  logic [W-1:0]  quo_nx;

  assign s      = {1'b0, in_up} + {1'b0, in_low};
  assign prod   = {{W{1'b0}}, s} * {{(W+1){1'b0}}, in_cent};
  assign num_nx = num_q + NW'(prod);
  assign den_nx = den_q + DW'(s);
  assign cnt_nx = cnt_q + CW'(1);
  assign cap    = (cnt_nx == CW'(N_RULES));

  assign in_ready  = Srst_n & EN_REGRAS & (state_q == S_ACC);
  assign xfer      = in_valid & in_ready;
  assign frame_end = in_last | cap;

`ifdef FUZZY_ROUND_EN
  assign div_ld = num_nx + NW'(den_nx >> 1);
`else
  assign div_ld = num_nx;
`endif

  // Quotient is known to fit in W bits, so the divisor starts at den<<(W-1).
  assign ge     = (rem_q >= dsh_q);
  assign quo_nx = {quo_q[W-2:0], ge};

  assign out_valid     = out_valid_q;
  assign saida_defuzzy = saida_q;
  assign n_regras      = n_regras_q;
  assign out_zero      = out_zero_q;
  assign out_ovf       = out_ovf_q;
  assign busy          = (state_q != S_ACC) | (cnt_q != '0);

  always_ff @(posedge clk_0 or negedge Srst_n) begin
    if (!Srst_n) begin
      state_q     <= S_ACC;
      num_q       <= '0;
      den_q       <= '0;
      cnt_q       <= '0;
      ncnt_q      <= '0;
      ovf_p_q     <= 1'b0;
      rem_q       <= '0;
      dsh_q       <= '0;
      quo_q       <= '0;
      step_q      <= '0;
      out_valid_q <= 1'b0;
      out_zero_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      saida_q     <= '0;
      n_regras_q  <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_ACC: if (xfer) begin
          if (frame_end) begin
            num_q   <= '0;
            den_q   <= '0;
            cnt_q   <= '0;
            ncnt_q  <= cnt_nx;
            ovf_p_q <= cap & ~in_last;
            if (den_nx == '0) begin
              // Nothing to divide; publish flags now and keep the previous crisp value.
              state_q     <= S_OUT;
              out_valid_q <= 1'b1;
              out_zero_q  <= 1'b1;
              n_regras_q  <= cnt_nx;
              out_ovf_q   <= cap & ~in_last;
            end else begin
              state_q <= S_DIV;
              rem_q   <= div_ld;
              dsh_q   <= NW'(den_nx) << (W-1);
              quo_q   <= '0;
              step_q  <= '0;
            end
          end else begin
            num_q <= num_nx;
            den_q <= den_nx;
            cnt_q <= cnt_nx;
          end
        end
        S_DIV: begin
          if (ge) rem_q <= rem_q - dsh_q;
          dsh_q  <= dsh_q >> 1;
          quo_q  <= quo_nx;
          step_q <= step_q + SW'(1);
          if (step_q == SW'(W-1)) begin
            state_q     <= S_OUT;
            out_valid_q <= 1'b1;
            saida_q     <= quo_nx;
            n_regras_q  <= ncnt_q;
            out_zero_q  <= 1'b0;
            out_ovf_q   <= ovf_p_q;
          end
        end
        S_OUT:   state_q <= S_ACC;
        default: state_q <= S_ACC;
      endcase
    end
  end
endmodule

// File: tb/tb_fuzzy_defuzzy_seq.sv
// Directed bench for fuzzy_defuzzy_seq: expected frames are queued on the last beat and checked on out_valid.
module tb_fuzzy_defuzzy_seq;
  localparam int W  = 8;
  localparam int NR = 9;
  localparam int CW = 4;
`ifdef FUZZY_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic          clk_0 = 1'b0;
  logic          Srst_n, EN_REGRAS, in_valid, in_last;
  logic [W-1:0]  in_up, in_low, in_cent;
  logic          in_ready, out_valid, out_zero, out_ovf, busy;
  logic [W-1:0]  saida_defuzzy;
  logic [CW-1:0] n_regras;

  fuzzy_defuzzy_seq #(.W(W), .N_RULES(NR)) dut (
    .clk_0(clk_0), .Srst_n(Srst_n), .EN_REGRAS(EN_REGRAS),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_up(in_up), .in_low(in_low), .in_cent(in_cent),
    .out_valid(out_valid), .saida_defuzzy(saida_defuzzy), .n_regras(n_regras),
    .out_zero(out_zero), .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk_0 = ~clk_0;

  int cyc = 0;
  always @(posedge clk_0) cyc <= cyc + 1;

  typedef struct {
    int q;
    int n;
    bit zero;
    bit ovf;
    int lat;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0, n_err = 0;
  int m_num = 0, m_den = 0, m_cnt = 0, last_q = 0;
  int acc_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    m_num = 0; m_den = 0; m_cnt = 0; last_q = 0;
    sb.delete();
  endtask

  // Arithmetic reference: weighted mean of centroids, pushed to the scoreboard at frame end.
  task automatic model_push(input int up, input int low, input int cent, input bit last);
    exp_t e;
    int s;
    s = up + low;
    m_num += s * cent;
    m_den += s;
    m_cnt++;
    if (last || m_cnt == NR) begin
      if (m_den != 0) last_q = (m_num + (RND ? m_den / 2 : 0)) / m_den;
      e.q = last_q; e.n = m_cnt; e.zero = (m_den == 0);
      e.ovf = (m_cnt == NR) && !last;
      e.lat = (m_den == 0) ? 0 : W;
      sb.push_back(e);
      m_num = 0; m_den = 0; m_cnt = 0;
    end
  endtask

  // Entered and left at a negedge; acc_cyc marks the accepting edge.
  task automatic send(input int up, input int low, input int cent, input bit last);
    bit ok;
    model_push(up, low, cent, last);
    in_up = W'(up); in_low = W'(low); in_cent = W'(cent); in_last = last; in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (in_ready === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk_0);
    end
    if (!ok) begin
      n_vec++; n_err++;
      $error("FAIL ready_timeout: in_ready stayed low for 50 cycles");
    end
    @(posedge clk_0);
    @(negedge clk_0);
    acc_cyc = cyc;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    exp_t e;
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid === 1'b1) begin got = 1'b1; break; end
      @(negedge clk_0);
    end
    if (!got || sb.size() == 0) begin
      n_vec++; n_err++;
      $error("FAIL %s_out: got out_valid=%0b queued=%0d, required a pulse with one queued frame", tag, got, sb.size());
      return;
    end
    e = sb.pop_front();
    chk({tag, "_lat"},  cyc - acc_cyc,  e.lat);
    chk({tag, "_q"},    saida_defuzzy,  e.q);
    chk({tag, "_n"},    n_regras,       e.n);
    chk({tag, "_zero"}, out_zero,       e.zero);
    chk({tag, "_ovf"},  out_ovf,        e.ovf);
    @(negedge clk_0);
    chk({tag, "_pulse"}, out_valid, 1'b0);
  endtask

  initial begin
    int seen;
    Srst_n = 1'b0; EN_REGRAS = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    in_up = '0; in_low = '0; in_cent = '0;
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_saida", saida_defuzzy, 0);
    chk("rst_ready", in_ready, 1'b0);
    repeat (2) @(negedge clk_0);
    Srst_n = 1'b1;
    @(negedge clk_0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_ready", in_ready, 1'b1);

    // 1: single beat
    send(100, 50, 200, 1'b1);
    chk("t1_div_ready", in_ready, 1'b0);
    chk("t1_div_busy", busy, 1'b1);
    wait_out("t1");

    // 2: two saturated beats, 127 truncated / 128 rounded
    send(255, 255, 0, 1'b0);
    chk("t2_part_busy", busy, 1'b1);
    send(255, 255, 255, 1'b1);
    wait_out("t2");

    // 3: zero-strength frame holds previous crisp value
    send(0, 0, 10, 1'b0);
    send(0, 0, 20, 1'b0);
    send(0, 0, 30, 1'b1);
    wait_out("t3");

    // 4: truncation at N_RULES, 10th beat opens a new frame
    for (int i = 0; i < 9; i++) send(10, 10, i * 20, 1'b0);
    wait_out("t4a");
    send(10, 10, 180, 1'b0);
    chk("t4_new_busy", busy, 1'b1);
    send(10, 10, 0, 1'b1);
    wait_out("t4b");

    // 5: unstalled reference then the same frame with a 5-cycle intake stall
    send(100, 50, 200, 1'b0);
    send(30, 20, 40, 1'b0);
    send(60, 60, 120, 1'b1);
    wait_out("t5ref");
    send(100, 50, 200, 1'b0);
    model_push(30, 20, 40, 1'b0);
    in_up = 8'd30; in_low = 8'd20; in_cent = 8'd40; in_last = 1'b0;
    in_valid = 1'b1; EN_REGRAS = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_0);
      chk("t5_stall_ready", in_ready, 1'b0);
    end
    chk("t5_stall_busy", busy, 1'b1);
    EN_REGRAS = 1'b1;
    @(posedge clk_0);
    @(negedge clk_0);
    in_valid = 1'b0;
    send(60, 60, 120, 1'b1);
    wait_out("t5stall");

    // 6: reset during divide discards the frame
    send(100, 50, 200, 1'b1);
    repeat (3) @(negedge clk_0);
    Srst_n = 1'b0;
    #1;
    chk("t6_valid", out_valid, 1'b0);
    chk("t6_saida", saida_defuzzy, 0);
    chk("t6_n", n_regras, 0);
    chk("t6_zero", out_zero, 1'b0);
    chk("t6_ovf", out_ovf, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_ready", in_ready, 1'b0);
    model_clear();
    @(negedge clk_0);
    Srst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_0);
      if (out_valid === 1'b1) seen++;
    end
    chk("t6_no_pulse", seen, 0);
    send(100, 50, 200, 1'b1);
    wait_out("t6rerun");

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fuzzy_defuzzy_seq.md
Name: fuzzy_defuzzy_seq

Overview:
Parametrised successor to the fixed 3-rule, 8-bit type-2 defuzzifier inside the fuzzy controller. Accepts a serial stream of per-rule firing strengths (upper/lower FOU bounds) with rule centroids. Accumulates Nie-Tan weighted sums and divides with a multi-cycle restoring divider to produce the crisp output. Sits between the rule-inference stage and the actuator register, single clock domain.

Parameters:
W, 8, width of strengths, centroids and crisp output
N_RULES, 9, maximum rules per frame (≥1)
CW, $clog2(N_RULES+1), rule-counter width (derived, do not override)

Ports:
clk_0  in  1  system clock, rising edge
Srst_n  in  1  asynchronous active-low reset
EN_REGRAS  in  1  rule-intake enable; gates in_ready only
in_valid  in  1  rule beat valid
in_ready  out  1  block accepts beat; transfer = in_valid & in_ready at clk_0 edge
in_last  in  1  last rule of frame
in_up  in  W  upper firing strength
in_low  in  W  lower firing strength
in_cent  in  W  rule consequent centroid
out_valid  out  1  one-cycle pulse, result valid
saida_defuzzy  out  W  crisp output, held between pulses
n_regras  out  CW  beats in completed frame, held
out_zero  out  1  frame had zero total strength, held
out_ovf  out  1  frame truncated at N_RULES without in_last, held
busy  out  1  state != S_ACC or frame partially accumulated

Behaviour:
- Reset (async assert, sync release): state S_ACC, accumulators 0, all outputs 0.
- Beat arithmetic: s = in_up + in_low (W+1 bits); num += s*in_cent (2W+1+CW bits); den += s (W+1+CW bits); cnt += 1. No overflow possible at these widths.
- S_ACC: in_ready = EN_REGRAS. On transfer, frame ends if in_last=1 or cnt+1 == N_RULES; out_ovf_next = (cnt+1==N_RULES & !in_last). At frame end: den_next==0 -> S_OUT with zero=1; otherwise -> S_DIV.
- S_DIV: in_ready=0; restoring division num/den, one quotient bit per cycle, exactly W cycles, then S_OUT. Quotient is always ≤ 2^W-1 (weighted mean of centroids); the low W bits are taken.
- S_OUT: single cycle: out_valid=1; saida_defuzzy <= quotient (unchanged if zero); n_regras, out_zero, out_ovf updated; accumulators/cnt cleared; -> S_ACC. in_ready=0.
- Latency: last beat accepted at edge k -> out_valid high during cycle k+W+1 (nonzero) or k+1 (zero). Next frame's first beat is accepted no earlier than edge k+W+2 (resp. k+2).
- EN_REGRAS low: intake stalls, partial sums retained; S_DIV/S_OUT proceed unaffected.
- in_valid with in_ready=0: beat is not consumed; source holds it.
- Beat after ovf truncation starts a new frame. No implicit frame carry-over.
- Reset mid-frame or mid-divide: partial frame discarded, no out_valid emitted.

Optional Feature:
FUZZY_ROUND_EN: when defined, numerator is loaded into the divider as num + (den>>1), giving round-half-up. Result still ≤ 2^W-1. When undefined, truncation. Latency is identical in both builds.

Test Plan:
1. Reset release, single beat up=100 low=50 cent=200 last=1 at edge k -> out_valid at cycle k+9, saida_defuzzy=200, n_regras=1, flags 0.
2. Beats (255,255,0), (255,255,255,last) -> num=130050, den=1020, saida_defuzzy=127 (128 with FUZZY_ROUND_EN).
3. After test 2, three beats all strength 0 with last on the third -> out_valid at k+1, out_zero=1, saida_defuzzy holds 127, n_regras=3.
4. Ten beats (10,10,c=i*20), no in_last -> first out_valid after the 9th beat with out_ovf=1, n_regras=9. The 10th beat opens a new frame.
5. EN_REGRAS low 5 cycles mid-frame with in_valid held -> in_ready=0 throughout, no beat lost; result identical to the unstalled run.
6. Srst_n pulsed low during S_DIV -> all outputs 0 immediately, no out_valid. Rerunning test 1 reproduces 200 at k+9.
